// File: rtl/mbc3_rtc_if.sv
// Pipelined Wishbone slave bus for the MBC3 real-time clock registers.
// Responses arrive one cycle after acceptance; STALL is never raised.
interface mbc3_rtc_if;
  logic       CYC;
  logic       STB;
  logic       WE;
  logic [2:0] ADDR;
  logic [7:0] DAT_ToTarget;
  logic [7:0] DAT_ToInitiator;
  logic       ACK;
  logic       STALL;

  modport slave (
    input  CYC, STB, WE, ADDR, DAT_ToTarget,
    output DAT_ToInitiator, ACK, STALL
  );

  modport master (
    output CYC, STB, WE, ADDR, DAT_ToTarget,
    input  DAT_ToInitiator, ACK, STALL
  );
endinterface

// File: rtl/mbc3_rtc.sv
// MBC3 cartridge RTC: live S/M/H/Day counters driven by a prescaler, plus latched copies for reads.
// Every accepted request gets its ACK (with registered read data) in the next cycle; never stalls.
module mbc3_rtc #(
  parameter int unsigned CLOCKS_PER_SECOND = 4194304
) (
  input  logic       CLK,
  input  logic       RST,
  mbc3_rtc_if.slave  bus
);

  localparam logic [23:0] PRESC_MAX = 24'(CLOCKS_PER_SECOND - 1);
  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_ARMED  = 1'b1;

  logic [5:0]  sec_q, sec_d;
  logic [5:0]  min_q, min_d;
  logic [4:0]  hour_q, hour_d;
  logic [8:0]  day_q, day_d;
  logic        halt_q, halt_d;
  logic        carry_q, carry_d;
  logic [23:0] presc_q, presc_d;

  logic [5:0]  l_sec_q, l_sec_d;
  logic [5:0]  l_min_q, l_min_d;
  logic [4:0]  l_hour_q, l_hour_d;
  logic [8:0]  l_day_q, l_day_d;
  logic        l_halt_q, l_halt_d;
  logic        l_carry_q, l_carry_d;

  logic [0:0]  state_q, state_d;
  logic        ack_q, ack_d;
  logic [7:0]  dat_q, dat_d;

  logic        accept;
  logic        wr;
  logic        rd;
  logic        field_wr;
  logic        tick;
  logic        s_carry;
  logic        m_carry;
  logic        h_carry;
  logic [7:0]  rdata;

  assign bus.STALL           = 1'b0;
  assign bus.ACK             = ack_q;
  assign bus.DAT_ToInitiator = dat_q;

  always_comb begin
    accept   = bus.CYC & bus.STB;
    wr       = accept & bus.WE;
    rd       = accept & ~bus.WE;
    field_wr = wr && (bus.ADDR <= 3'd4);
    tick     = !halt_q && (presc_q == PRESC_MAX);

    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    day_d     = day_q;
    halt_d    = halt_q;
    carry_d   = carry_q;
    presc_d   = presc_q;
    l_sec_d   = l_sec_q;
    l_min_d   = l_min_q;
    l_hour_d  = l_hour_q;
    l_day_d   = l_day_q;
    l_halt_d  = l_halt_q;
    l_carry_d = l_carry_q;
    state_d   = state_q;
    s_carry   = 1'b0;
    m_carry   = 1'b0;
    h_carry   = 1'b0;

    if (!halt_q) begin
      presc_d = tick ? 24'd0 : presc_q + 24'd1;
    end

    // A field write in the same cycle swallows the whole tick so the write lands unmodified.
    if (tick && !field_wr) begin
      if (sec_q == 6'd59) begin
        sec_d   = 6'd0;
        s_carry = 1'b1;
      end else if (sec_q == 6'd63) begin
        sec_d = 6'd0;
      end else begin
        sec_d = sec_q + 6'd1;
      end

      if (s_carry) begin
        if (min_q == 6'd59) begin
          min_d   = 6'd0;
          m_carry = 1'b1;
        end else if (min_q == 6'd63) begin
          min_d = 6'd0;
        end else begin
          min_d = min_q + 6'd1;
        end
      end

      if (m_carry) begin
        if (hour_q == 5'd23) begin
          hour_d  = 5'd0;
          h_carry = 1'b1;
        end else if (hour_q == 5'd31) begin
          hour_d = 5'd0;
        end else begin
          hour_d = hour_q + 5'd1;
        end
      end

      if (h_carry) begin
        day_d = day_q + 9'd1;
        if (day_q == 9'd511) begin
          carry_d = 1'b1;
        end
      end
    end

    if (wr) begin
      case (bus.ADDR)
        3'd0: begin
          sec_d   = bus.DAT_ToTarget[5:0];
          presc_d = 24'd0;
        end
        3'd1: min_d       = bus.DAT_ToTarget[5:0];
        3'd2: hour_d      = bus.DAT_ToTarget[4:0];
        3'd3: day_d[7:0]  = bus.DAT_ToTarget;
        3'd4: begin
          day_d[8] = bus.DAT_ToTarget[0];
          halt_d   = bus.DAT_ToTarget[6];
          carry_d  = bus.DAT_ToTarget[7];
        end
        3'd5: begin
          // Latch on the 0x00 -> 0x01 sequence; copies use pre-tick values.
          if (bus.DAT_ToTarget == 8'h00) begin
            state_d = ST_ARMED;
          end else if (bus.DAT_ToTarget == 8'h01 && state_q == ST_ARMED) begin
            l_sec_d   = sec_q;
            l_min_d   = min_q;
            l_hour_d  = hour_q;
            l_day_d   = day_q;
            l_halt_d  = halt_q;
            l_carry_d = carry_q;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end

    case (bus.ADDR)
      3'd0:    rdata = {2'b00, l_sec_q};
      3'd1:    rdata = {2'b00, l_min_q};
      3'd2:    rdata = {3'b000, l_hour_q};
      3'd3:    rdata = l_day_q[7:0];
      3'd4:    rdata = {l_carry_q, l_halt_q, 5'b00000, l_day_q[8]};
      default: rdata = 8'hFF;
    endcase

    ack_d = accept;
    dat_d = rd ? rdata : 8'h00;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      day_q     <= '0;
      halt_q    <= 1'b0;
      carry_q   <= 1'b0;
      presc_q   <= '0;
      l_sec_q   <= '0;
      l_min_q   <= '0;
      l_hour_q  <= '0;
      l_day_q   <= '0;
      l_halt_q  <= 1'b0;
      l_carry_q <= 1'b0;
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      day_q     <= day_d;
      halt_q    <= halt_d;
      carry_q   <= carry_d;
      presc_q   <= presc_d;
      l_sec_q   <= l_sec_d;
      l_min_q   <= l_min_d;
      l_hour_q  <= l_hour_d;
      l_day_q   <= l_day_d;
      l_halt_q  <= l_halt_d;
      l_carry_q <= l_carry_d;
      state_q   <= state_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

endmodule

// File: tb/tb_mbc3_rtc.sv
// Directed bench for mbc3_rtc: requests push expected responses into a queue, a monitor checks ACKs.
module tb_mbc3_rtc;

  typedef struct {
    int         cyc;
    bit         chk;
    logic [7:0] d;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc_cnt;
  int   tests;
  int   fails;
  exp_t q[$];

  mbc3_rtc_if bus ();

  mbc3_rtc #(.CLOCKS_PER_SECOND(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: every ACK must match the oldest outstanding request, in the expected cycle.
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (bus.STALL !== 1'b0) begin
        fails++;
        $display("FAIL stall: STALL=%b required 0 at cycle %0d", bus.STALL, cyc_cnt);
      end
    end
    if (bus.ACK === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: ACK=1 at cycle %0d with no request outstanding", cyc_cnt);
      end else begin
        if (q[0].cyc != cyc_cnt) begin
          fails++;
          $display("FAIL ack_timing: ACK at cycle %0d required cycle %0d", cyc_cnt, q[0].cyc);
        end else if (q[0].chk && bus.DAT_ToInitiator !== q[0].d) begin
          fails++;
          $display("FAIL read_data: got %02h required %02h at cycle %0d",
                   bus.DAT_ToInitiator, q[0].d, cyc_cnt);
        end
        void'(q.pop_front());
      end
    end else begin
      tests++;
      if (bus.DAT_ToInitiator !== 8'h00) begin
        fails++;
        $display("FAIL idle_data: DAT=%02h required 00 with ACK=0 at cycle %0d",
                 bus.DAT_ToInitiator, cyc_cnt);
      end
      if (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        tests++;
        fails++;
        $display("FAIL missing_ack: ACK=0 at cycle %0d required 1", cyc_cnt);
        void'(q.pop_front());
      end
    end
  end

  task automatic req(input bit we_i, input logic [2:0] a, input logic [7:0] d,
                     input bit chk, input logic [7:0] exp_d);
    exp_t e;
    bus.CYC          = 1'b1;
    bus.STB          = 1'b1;
    bus.WE           = we_i;
    bus.ADDR         = a;
    bus.DAT_ToTarget = d;
    e.cyc = cyc_cnt + 1;
    e.chk = chk;
    e.d   = exp_d;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    req(1'b1, a, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp_d);
    req(1'b0, a, 8'h00, 1'b1, exp_d);
  endtask

  task automatic idle(input int n);
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
    bus.WE  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp_v);
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s: got %02h required %02h", name, got, exp_v);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
    bus.WE = 1'b0;
    bus.ADDR = 3'd0;
    bus.DAT_ToTarget = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ack", {7'd0, bus.ACK}, 8'h00);
    check("reset_dat", bus.DAT_ToInitiator, 8'h00);

    // Latched registers after reset
    rd(0, 8'h00); rd(1, 8'h00); rd(2, 8'h00); rd(3, 8'h00); rd(4, 8'h00);
    idle(2);

    // Halt, set S=7; broken latch sequences must not copy
    wr(4, 8'h40); wr(0, 8'h07);
    wr(5, 8'h00); wr(5, 8'h02); wr(5, 8'h01);
    rd(0, 8'h00); rd(4, 8'h00);
    wr(5, 8'h00); wr(5, 8'h01);
    rd(0, 8'h07); rd(4, 8'h40);
    idle(1);

    // Full rollover: 58:59:23 day 511 -> two ticks -> all zero with day carry
    wr(1, 8'd59); wr(2, 8'd23); wr(3, 8'hFF); wr(4, 8'h01); wr(0, 8'd58);
    idle(8);
    wr(5, 8'h00); wr(5, 8'h01);
    rd(0, 8'h00); rd(1, 8'h00); rd(2, 8'h00); rd(3, 8'h00); rd(4, 8'h80);

    // S=63 wraps to 0 without carrying into M
    wr(1, 8'd5); wr(0, 8'd63);
    idle(4);
    wr(5, 8'h00); wr(5, 8'h01);
    wr(4, 8'h40);
    rd(0, 8'h00); rd(1, 8'h05); rd(4, 8'h80);

    // Halted: 100 cycles later everything is frozen
    idle(100);
    wr(5, 8'h00); wr(5, 8'h01);
    rd(0, 8'h00); rd(1, 8'h05); rd(2, 8'h00); rd(3, 8'h00); rd(4, 8'h40);

    // Back-to-back reads including unmapped addresses
    rd(0, 8'h00); rd(4, 8'h40); rd(5, 8'hFF); rd(7, 8'hFF); rd(6, 8'hFF);
    idle(1);

    // Accepted request followed by reset; a request held during reset is ignored
    rd(1, 8'h05);
    rst = 1'b1;
    bus.ADDR = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
    check("ack_after_reset", {7'd0, bus.ACK}, 8'h00);
    idle(1);
    rd(0, 8'h00); rd(1, 8'h00); rd(2, 8'h00); rd(3, 8'h00); rd(4, 8'h00);
    idle(3);

    check("outstanding", 8'(q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mbc3_rtc.md
MBC3_RTC -- requirements
Module: mbc3_rtc

Interface
REQ-001 SHALL have parameter CLOCKS_PER_SECOND, default 4194304: CLK cycles per RTC second; legal range 2 to 2^24.
REQ-002 SHALL have port CLK, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port CYC, input, 1: Wishbone bus cycle valid.
REQ-005 SHALL have port STB, input, 1: Wishbone request strobe (pipelined mode).
REQ-006 SHALL have port WE, input, 1: request is a write.
REQ-007 SHALL have port ADDR, input, 3: register index.
REQ-008 SHALL have port DAT_ToTarget, input, 8: write data.
REQ-009 SHALL have port DAT_ToInitiator, output, 8: read data, valid while ACK=1.
REQ-010 SHALL have port ACK, output, 1: one-cycle response strobe.
REQ-011 SHALL have port STALL, output, 1: tied to 0.

Function
REQ-012 SHALL accept a request in any cycle with CYC=1 and STB=1; back-to-back requests in consecutive cycles SHALL each be accepted.
REQ-013 SHALL assert ACK for exactly one cycle, in the cycle after acceptance, regardless of CYC in that cycle; exactly one ACK per accepted request.
REQ-014 SHALL hold live counters: S (6b), M (6b), H (5b), Day (9b), Halt (1b), Carry (1b), and a 24-bit prescaler.
REQ-015 SHALL hold latched copies LS, LM, LH, LDay, LHalt, LCarry; reads SHALL return latched copies only.
REQ-016 SHALL decode reads by ADDR: 0 -> {00,LS}; 1 -> {00,LM}; 2 -> {000,LH}; 3 -> LDay[7:0]; 4 -> {LCarry,LHalt,00000,LDay[8]}; 5-7 -> 8'hFF.
REQ-017 SHALL register DAT_ToInitiator with ACK; it SHALL be 0 in cycles where ACK=0.
REQ-018 SHALL decode writes: 0 -> S=D[5:0] and prescaler cleared; 1 -> M=D[5:0]; 2 -> H=D[4:0]; 3 -> Day[7:0]=D; 4 -> Day[8]=D[0], Halt=D[6], Carry=D[7]; 5 -> latch FSM; 6-7 ignored but ACKed.
REQ-019 Writes to 0-4 SHALL update live counters only, never latched copies.
REQ-020 Latch FSM SHALL have states IDLE and ARMED: write D=8'h00 to ADDR 5 -> ARMED; write D=8'h01 in ARMED -> copy all live values to latched, go IDLE; any other write to ADDR 5 -> IDLE; writes to other addresses do not change state.
REQ-021 Latch copy SHALL capture live values as of the start of the accepting cycle (pre-tick).
REQ-022 When Halt=0, prescaler SHALL increment each cycle; at CLOCKS_PER_SECOND-1 it SHALL wrap to 0 and generate one tick; when Halt=1 prescaler and counters SHALL freeze.
REQ-023 On tick: S=59 -> 0 with carry to M; S=63 -> 0 without carry; else S+1. M identical rule into H. H=23 -> 0 with carry to Day; H=31 -> 0 without carry; else H+1.
REQ-024 Day carry-in SHALL increment Day mod 512; 511 -> 0 SHALL set Carry=1; Carry is sticky, cleared only by write or reset.
REQ-025 A write to ADDR 0-4 in a tick cycle SHALL suppress that entire tick; the written field takes the written value, all other fields unchanged.
REQ-026 Writing Halt=1 SHALL freeze from the next cycle; writing Halt=0 resumes with the prescaler unchanged.

Reset
REQ-027 On RST=1 at a clock edge: all live and latched counters, Halt, Carry, prescaler = 0; latch FSM = IDLE; ACK=0; DAT_ToInitiator=0.
REQ-028 RST SHALL abort any pending response: no ACK in the cycle after a reset cycle, even if a request was accepted in the previous cycle.
REQ-029 Requests presented during RST=1 SHALL not be accepted.

Verification
REQ-030 CLOCKS_PER_SECOND=4; write S=58, M=59, H=23, Day=511; run 8 cycles; latch (0x00 then 0x01 to ADDR 5) -> reads 0/0/0/0x00, DH read 0x80.
REQ-031 Write S=63; run 1 tick; latch -> S=0, M unchanged.
REQ-032 Write DH=0x40 (halt); run 100 cycles; latch -> values unchanged from before halt.
REQ-033 Writes 0x00, 0x02, 0x01 to ADDR 5 -> no latch; latched values stay 0. Writes 0x00, 0x01 -> latch occurs.
REQ-034 Four back-to-back reads of ADDR 0,4,5,7 -> four consecutive ACKs, data LS, DH byte, 0xFF, 0xFF; STALL=0 throughout.
REQ-035 Accept request, assert RST next cycle -> ACK=0 following, all reads return 0 after reset.
